traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
Passive checker on the receiving end of the 3-bit `lights` bus driven by the traffic-light FSM. It samples the light code every clock and tracks the current phase. It checks phase order and per-phase dwell time, raises sticky error flags, and counts completed light cycles. It sits beside the FSM in system builds and benches and never drives the FSM.

Parameters:
- GREEN_MIN, 4, minimum legal green dwell in clocks
- GREEN_MAX, 8, maximum legal green dwell in clocks
- YELLOW_CYCLES, 2, exact legal yellow dwell in clocks
- RED_MIN, 4, minimum legal red dwell in clocks
- RED_MAX, 8, maximum legal red dwell in clocks
- CNT_W, 8, dwell counter width; every MAX parameter + 1 must be below 2^CNT_W

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state immediately
- lights_in  in  3  observed light code: [2]=red, [1]=yellow, [0]=green, one-hot
- clear_err  in  1  synchronous clear of all sticky error flags
- phase  out  2  tracked phase: 00 SYNC, 01 GREEN, 10 YELLOW, 11 RED
- dwell_cnt  out  CNT_W  clocks the current phase has been held, saturating
- cycle_count  out  16  count of legal RED->GREEN transitions, wraps 65535->0
- cycle_done  out  1  one-clock pulse on each legal RED->GREEN transition
- err_illegal_code  out  1  sticky; non-one-hot code seen (includes 000)
- err_bad_order  out  1  sticky; transition not GREEN->YELLOW->RED->GREEN
- err_dwell  out  1  sticky; phase length outside its [MIN,MAX]
- err_any  out  1  OR of the three sticky flags (registered)

Behaviour:
- Reset (rst=0, asynchronous): phase=SYNC, dwell_cnt=0, cycle_count=0, cycle_done=0, all err_* = 0, first_phase flag = 1. All outputs are registered. Every effect below becomes visible after the rising edge that samples the triggering lights_in value.
- Legal codes: 001 GREEN, 010 YELLOW, 100 RED. Any other code is illegal and causes:
  - err_illegal_code <= 1
  - phase <= SYNC, dwell_cnt <= 0, first_phase <= 1
- SYNC: on a legal code, phase <= that phase, dwell_cnt <= 1, with no order check. first_phase stays 1 for this phase, and its dwell is not min-checked because it may be partial. The max check still applies.
- Same code as the tracked phase: dwell_cnt <= dwell_cnt + 1, saturating at all-ones. On the edge where dwell_cnt would become phase MAX + 1, err_dwell <= 1. YELLOW uses YELLOW_CYCLES as MAX.
- Legal code that differs from the tracked phase (transition):
  - Exit check: if first_phase = 0 and the outgoing dwell_cnt < phase MIN (YELLOW_CYCLES for yellow), err_dwell <= 1.
  - Order check: the successor must be GREEN->YELLOW, YELLOW->RED or RED->GREEN; otherwise err_bad_order <= 1. On a bad order, phase still follows the observed code (resync), and no cycle_done is raised.
  - In all cases: phase <= new phase, dwell_cnt <= 1, first_phase <= 0.
  - A legal RED->GREEN transition sets cycle_done <= 1 for one clock and increments cycle_count (mod 2^16). It still counts if the red dwell was out of range; err_dwell reports that separately.
- cycle_done is 0 in every other cycle.
- clear_err=1 clears all err_* on the next edge. If a new error event occurs on the same edge, the set wins and that flag reads 1. err_any reflects the flag values being written on the same edge.
- clear_err does not touch phase, dwell_cnt or cycle_count.
- When rst is asserted mid-phase, all outputs drop to their reset values without waiting for clk. After release, the monitor restarts in SYNC.

Test Plan:
1. Reset, then drive GREEN x6, YELLOW x2, RED x5, GREEN -> phase walks 01,10,11,01. cycle_done pulses once on GREEN re-entry, cycle_count=1, all err_*=0. The initial partial green is not min-checked.
2. After a legal GREEN x5, drive RED -> err_bad_order=1, err_any=1, phase=11, dwell_cnt=1, cycle_count unchanged.
3. Drive 3'b110 for one clock, then GREEN -> err_illegal_code=1, phase=00 and dwell_cnt=0 after the bad sample. The next sample puts phase=01 with no bad-order error.
4. Legal cycle with YELLOW held 3 clocks -> err_dwell=1 on the edge sampling the 3rd yellow. With YELLOW held 1 clock instead, err_dwell=1 on the edge sampling RED.
5. With err_dwell=1, pulse clear_err for one clock with a clean sample -> all err_*=0. Repeat clear_err on the same edge as an illegal code -> err_illegal_code=1 and err_any=1.
6. Assert rst for 3 ns mid-RED (dwell_cnt=3, cycle_count=2) -> phase=00, dwell_cnt=0, cycle_count=0 immediately. After release, GREEN -> phase=01, dwell_cnt=1.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//
// Passive checker for the 3-bit one-hot light bus produced by the traffic-light
// FSM. It follows the observed phase, measures how long each phase is held,
// flags illegal codes, out-of-order transitions and out-of-range dwell times
// (all sticky), and counts completed RED->GREEN cycles. Never drives the FSM.
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous active-low reset
//   lights_in[2:0]   observed code: [2]=red, [1]=yellow, [0]=green
//   clear_err        synchronous clear of the sticky error flags
//   phase[1:0]       tracked phase: 00 SYNC, 01 GREEN, 10 YELLOW, 11 RED
//   dwell_cnt        clocks the current phase has been held (saturating)
//   cycle_count[15:0] legal RED->GREEN transitions, wraps
//   cycle_done       one-clock pulse on each legal RED->GREEN transition
//   err_illegal_code sticky: non-one-hot code seen
//   err_bad_order    sticky: transition out of GREEN->YELLOW->RED order
//   err_dwell        sticky: phase held outside its [MIN,MAX] window
//   err_any          registered OR of the three sticky flags
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
  parameter int unsigned GREEN_MIN     = 4,
  parameter int unsigned GREEN_MAX     = 8,
  parameter int unsigned YELLOW_CYCLES = 2,
  parameter int unsigned RED_MIN       = 4,
  parameter int unsigned RED_MAX       = 8,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       lights_in,
  input  logic             clear_err,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell_cnt,
  output logic [15:0]      cycle_count,
  output logic             cycle_done,
  output logic             err_illegal_code,
  output logic             err_bad_order,
  output logic             err_dwell,
  output logic             err_any
);

  typedef enum logic [1:0] {
    PH_SYNC   = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10,
    PH_RED    = 2'b11
  } phase_e;

  localparam logic [CNT_W-1:0] GREEN_MIN_C = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] GREEN_MAX_C = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] YELLOW_C    = CNT_W'(YELLOW_CYCLES);
  localparam logic [CNT_W-1:0] RED_MIN_C   = CNT_W'(RED_MIN);
  localparam logic [CNT_W-1:0] RED_MAX_C   = CNT_W'(RED_MAX);
  localparam logic [CNT_W-1:0] DWELL_ONE   = CNT_W'(1);

  // State
  phase_e           phase_q,            phase_d;
  logic [CNT_W-1:0] dwell_q,            dwell_d;
  logic [15:0]      cycle_count_q,      cycle_count_d;
  logic             cycle_done_q,       cycle_done_d;
  logic             first_q,            first_d;
  logic             err_illegal_q,      err_illegal_d;
  logic             err_order_q,        err_order_d;
  logic             err_dwell_q,        err_dwell_d;
  logic             err_any_q,          err_any_d;

  // Decode helpers
  logic             code_legal;
  phase_e           code_phase;
  phase_e           succ_phase;
  logic [CNT_W-1:0] cur_min;
  logic [CNT_W-1:0] cur_max;
  logic             set_illegal;
  logic             set_order;
  logic             set_dwell;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q       <= PH_SYNC;
      dwell_q       <= '0;
      cycle_count_q <= '0;
      cycle_done_q  <= 1'b0;
      first_q       <= 1'b1;
      err_illegal_q <= 1'b0;
      err_order_q   <= 1'b0;
      err_dwell_q   <= 1'b0;
      err_any_q     <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      dwell_q       <= dwell_d;
      cycle_count_q <= cycle_count_d;
      cycle_done_q  <= cycle_done_d;
      first_q       <= first_d;
      err_illegal_q <= err_illegal_d;
      err_order_q   <= err_order_d;
      err_dwell_q   <= err_dwell_d;
      err_any_q     <= err_any_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default at the top of the block so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    code_legal    = 1'b1;
    code_phase    = PH_SYNC;
    succ_phase    = PH_SYNC;
    cur_min       = '0;
    cur_max       = '0;
    set_illegal   = 1'b0;
    set_order     = 1'b0;
    set_dwell     = 1'b0;
    phase_d       = phase_q;
    dwell_d       = dwell_q;
    first_d       = first_q;
    cycle_count_d = cycle_count_q;
    cycle_done_d  = 1'b0;

    case (lights_in)
      3'b001:  code_phase = PH_GREEN;
      3'b010:  code_phase = PH_YELLOW;
      3'b100:  code_phase = PH_RED;
      default: code_legal = 1'b0;
    endcase

    // Dwell window and legal successor of the phase being left/extended.
    // Yellow has a single exact length, so its MIN and MAX coincide.
    case (phase_q)
      PH_GREEN:  begin cur_min = GREEN_MIN_C; cur_max = GREEN_MAX_C; succ_phase = PH_YELLOW; end
      PH_YELLOW: begin cur_min = YELLOW_C;    cur_max = YELLOW_C;    succ_phase = PH_RED;    end
      PH_RED:    begin cur_min = RED_MIN_C;   cur_max = RED_MAX_C;   succ_phase = PH_GREEN;  end
      default:   begin cur_min = '0;          cur_max = '0;          succ_phase = PH_SYNC;   end
    endcase

    if (!code_legal) begin
      // Lose lock: restart tracking as if just out of reset.
      set_illegal = 1'b1;
      phase_d     = PH_SYNC;
      dwell_d     = '0;
      first_d     = 1'b1;
    end else if (phase_q == PH_SYNC) begin
      // Joining mid-stream: the first phase may be partial, so first_q stays
      // set and suppresses its minimum-length check on exit.
      phase_d = code_phase;
      dwell_d = DWELL_ONE;
    end else if (code_phase == phase_q) begin
      if (dwell_q != '1) begin
        dwell_d = dwell_q + DWELL_ONE;
      end
      // Fires exactly once, on the edge the count would reach MAX + 1.
      if (dwell_q == cur_max) begin
        set_dwell = 1'b1;
      end
    end else begin
      if (!first_q && (dwell_q < cur_min)) begin
        set_dwell = 1'b1;
      end
      if (code_phase != succ_phase) begin
        set_order = 1'b1;
      end else if (phase_q == PH_RED) begin
        cycle_done_d  = 1'b1;
        cycle_count_d = cycle_count_q + 16'd1;
      end
      phase_d = code_phase;
      dwell_d = DWELL_ONE;
      first_d = 1'b0;
    end

    // A new error event on the same edge as clear_err wins.
    err_illegal_d = (err_illegal_q & ~clear_err) | set_illegal;
    err_order_d   = (err_order_q   & ~clear_err) | set_order;
    err_dwell_d   = (err_dwell_q   & ~clear_err) | set_dwell;
    err_any_d     = err_illegal_d | err_order_d | err_dwell_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  always_comb begin
    phase            = phase_q;
    dwell_cnt        = dwell_q;
    cycle_count      = cycle_count_q;
    cycle_done       = cycle_done_q;
    err_illegal_code = err_illegal_q;
    err_bad_order    = err_order_q;
    err_dwell        = err_dwell_q;
    err_any          = err_any_q;
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_monitor
//
// Drives directed scenarios followed by randomized light sequences into
// traffic_light_monitor. A behavioural model tracks the current run of
// identical codes (its code, unbounded length, and whether it is the first run
// after lock) and derives every expected output from it; a compare process
// checks all outputs on every falling edge while out of reset. Directed
// scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_traffic_light_monitor;

  localparam int GMIN = 4;
  localparam int GMAX = 8;
  localparam int YC   = 2;
  localparam int RMIN = 4;
  localparam int RMAX = 8;
  localparam int CW   = 8;
  localparam int SAT  = (1 << CW) - 1;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic [2:0]    lights_in = 3'b001;
  logic          clear_err = 1'b0;
  logic [1:0]    phase;
  logic [CW-1:0] dwell_cnt;
  logic [15:0]   cycle_count;
  logic          cycle_done;
  logic          err_illegal_code;
  logic          err_bad_order;
  logic          err_dwell;
  logic          err_any;

  int checks   = 0;
  int failures = 0;

  traffic_light_monitor #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_CYCLES(YC),
    .RED_MIN(RMIN), .RED_MAX(RMAX), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lights_in(lights_in),
    .clear_err(clear_err),
    .phase(phase),
    .dwell_cnt(dwell_cnt),
    .cycle_count(cycle_count),
    .cycle_done(cycle_done),
    .err_illegal_code(err_illegal_code),
    .err_bad_order(err_bad_order),
    .err_dwell(err_dwell),
    .err_any(err_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: one "run" of identical legal codes
  // ---------------------------------------------------------------------------
  logic [2:0] m_code   = 3'b000;   // 000 = not locked (SYNC)
  int         m_len    = 0;
  bit         m_first  = 1'b1;
  int         m_cycles = 0;
  bit         m_done   = 1'b0;
  bit         m_ei     = 1'b0;
  bit         m_eo     = 1'b0;
  bit         m_ed     = 1'b0;
  bit         s_i, s_o, s_d;

  function automatic int min_of(input logic [2:0] c);
    case (c)
      G:       return GMIN;
      Y:       return YC;
      R:       return RMIN;
      default: return 0;
    endcase
  endfunction

  function automatic int max_of(input logic [2:0] c);
    case (c)
      G:       return GMAX;
      Y:       return YC;
      R:       return RMAX;
      default: return 0;
    endcase
  endfunction

  // Legal successor of a one-hot code is its rotate-left: G->Y->R->G.
  function automatic logic [2:0] rotl(input logic [2:0] c);
    return {c[1:0], c[2]};
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_code = 3'b000; m_len = 0; m_first = 1'b1; m_cycles = 0;
        m_done = 1'b0; m_ei = 1'b0; m_eo = 1'b0; m_ed = 1'b0;
      end else begin
        s_i = 1'b0; s_o = 1'b0; s_d = 1'b0; m_done = 1'b0;
        if (!$onehot(lights_in)) begin
          s_i = 1'b1; m_code = 3'b000; m_len = 0; m_first = 1'b1;
        end else if (m_code == 3'b000) begin
          m_code = lights_in; m_len = 1;
        end else if (lights_in == m_code) begin
          m_len++;
          if (m_len == max_of(m_code) + 1) s_d = 1'b1;
        end else begin
          if (!m_first && m_len < min_of(m_code)) s_d = 1'b1;
          if (lights_in != rotl(m_code)) s_o = 1'b1;
          else if (m_code == R) begin
            m_done = 1'b1;
            m_cycles = (m_cycles + 1) % 65536;
          end
          m_code = lights_in; m_len = 1; m_first = 1'b0;
        end
        m_ei = (m_ei && !clear_err) || s_i;
        m_eo = (m_eo && !clear_err) || s_o;
        m_ed = (m_ed && !clear_err) || s_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: every falling edge while out of reset
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("phase",       phase,       (m_code == 3'b000) ? 0 : $clog2(m_code) + 1);
        check("dwell_cnt",   dwell_cnt,   (m_len > SAT) ? SAT : m_len);
        check("cycle_count", cycle_count, m_cycles);
        check("cycle_done",  cycle_done,  m_done);
        check("err_illegal", err_illegal_code, m_ei);
        check("err_order",   err_bad_order,    m_eo);
        check("err_dwell",   err_dwell,        m_ed);
        check("err_any",     err_any,          m_ei | m_eo | m_ed);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [2:0] c, input logic clr, input int n);
    for (int k = 0; k < n; k++) begin
      lights_in = c;
      clear_err = clr;
      @(negedge clk);
    end
    clear_err = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #4 rst = 1'b1;
    @(negedge clk);
  endtask

  logic [2:0] cur;
  logic [2:0] nxt;
  int         r;
  int         n;

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_phase", phase, 0);
    check("rst_dwell", dwell_cnt, 0);
    check("rst_cycles", cycle_count, 0);
    check("rst_err_any", err_any, 0);

    // 1: one legal cycle from a partial green
    drive(G, 0, 1);
    check("t1_phase_g", phase, 1);
    check("t1_dwell_1", dwell_cnt, 1);
    drive(G, 0, 5);
    check("t1_dwell_6", dwell_cnt, 6);
    drive(Y, 0, 2);
    check("t1_phase_y", phase, 2);
    drive(R, 0, 5);
    check("t1_phase_r", phase, 3);
    check("t1_done_lo", cycle_done, 0);
    drive(G, 0, 1);
    check("t1_phase_g2", phase, 1);
    check("t1_done_hi", cycle_done, 1);
    check("t1_cycles", cycle_count, 1);
    check("t1_err_any", err_any, 0);

    // 2: green straight to red
    drive(G, 0, 4);
    check("t2_done_lo", cycle_done, 0);
    drive(R, 0, 1);
    check("t2_order", err_bad_order, 1);
    check("t2_any", err_any, 1);
    check("t2_phase", phase, 3);
    check("t2_dwell", dwell_cnt, 1);
    check("t2_cycles", cycle_count, 1);
    drive(R, 1, 1);
    check("t2_cleared", err_any, 0);

    // 3: illegal code then green
    drive(3'b110, 0, 1);
    check("t3_illegal", err_illegal_code, 1);
    check("t3_phase", phase, 0);
    check("t3_dwell", dwell_cnt, 0);
    drive(G, 0, 1);
    check("t3_phase_g", phase, 1);
    check("t3_no_order", err_bad_order, 0);

    // 4a: yellow held 3 clocks
    drive(G, 0, 4);
    drive(Y, 0, 2);
    check("t4_y2_ok", err_dwell, 0);
    drive(Y, 0, 1);
    check("t4_y3_err", err_dwell, 1);

    // 5a: clean clear
    drive(R, 1, 1);
    check("t5_clr_dwell", err_dwell, 0);
    check("t5_clr_illegal", err_illegal_code, 0);
    check("t5_clr_any", err_any, 0);

    // 4b: yellow held 1 clock
    drive(R, 0, 4);
    drive(G, 0, 1);
    check("t4_cycles", cycle_count, 2);
    drive(G, 0, 4);
    drive(Y, 0, 1);
    check("t4_y1_ok", err_dwell, 0);
    drive(R, 0, 1);
    check("t4_r_err", err_dwell, 1);

    // 5b: clear on the same edge as an illegal code
    drive(3'b000, 1, 1);
    check("t5_set_wins", err_illegal_code, 1);
    check("t5_dwell_clr", err_dwell, 0);
    check("t5_any", err_any, 1);

    // 6: asynchronous reset mid-red
    do_reset();
    drive(G, 0, 5); drive(Y, 0, 2); drive(R, 0, 5);
    drive(G, 0, 5); drive(Y, 0, 2); drive(R, 0, 5);
    drive(G, 0, 5); drive(Y, 0, 2); drive(R, 0, 3);
    check("t6_pre_dwell", dwell_cnt, 3);
    check("t6_pre_cycles", cycle_count, 2);
    #1 rst = 1'b0;
    lights_in = G;
    #1;
    check("t6_async_phase", phase, 0);
    check("t6_async_dwell", dwell_cnt, 0);
    check("t6_async_cycles", cycle_count, 0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("t6_restart_phase", phase, 1);
    check("t6_restart_dwell", dwell_cnt, 1);

    // dwell counter saturation
    drive(G, 0, 299);
    check("sat_dwell", dwell_cnt, SAT);
    check("sat_err", err_dwell, 1);

    // randomized sequences
    do_reset();
    cur = R;
    for (int s = 0; s < 300; s++) begin
      r = $urandom_range(0, 99);
      if (r < 85) begin
        nxt = rotl(cur);
        n = $urandom_range(1, 10);
      end else if (r < 93) begin
        nxt = 3'b001 << $urandom_range(0, 2);
        n = $urandom_range(1, 4);
      end else begin
        case ($urandom_range(0, 4))
          0:       nxt = 3'b000;
          1:       nxt = 3'b011;
          2:       nxt = 3'b101;
          3:       nxt = 3'b110;
          default: nxt = 3'b111;
        endcase
        n = $urandom_range(1, 3);
      end
      for (int k = 0; k < n; k++) begin
        drive(nxt, ($urandom_range(0, 7) == 0), 1);
      end
      if ($onehot(nxt)) cur = nxt;
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
